// File: rtl/cpu_debug_ctrl_pkg.sv
// Shared types and constants for the CPU debug controller: FSM states,
// monitor window offsets and status register bit positions.
package cpu_debug_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_STOP,
    ST_ARMED,
    ST_STEPPING,
    ST_RESETSTEP
  } dbg_state_e;

  // Offsets 0..6 are acc, x, y, sp, pcl, pch, sr in that order.
  localparam logic [3:0] OFF_REG_LAST = 4'd6;
  localparam logic [3:0] OFF_STATUS   = 4'd7;

  localparam int STAT_STOPPED_BIT = 7;
  localparam int STAT_BP_BIT      = 6;
  localparam int STAT_STEP_BIT    = 5;

endpackage

// File: rtl/cpu_debug_ctrl_nmi_pulse_gen.sv
// Fixed-width active-low NMI pulse generator; a new fire request restarts
// the count so the pulse always ends NMI_LEN cycles after the last request.
module nmi_pulse_gen #(
  parameter int NMI_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic nmi_n
);

  localparam int CW = $clog2(NMI_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      cnt_d = CW'(NMI_LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nmi_n = (cnt_q == '0);

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Debug controller for a 6502-style CPU: monitor register window, breakpoints,
// halt / single- and multi-step control, and NMI generation.
module cpu_debug_ctrl
  import cpu_debug_ctrl_pkg::*;
#(
  parameter logic [7:0] WIN_BASE = 8'hE0,
  parameter int         NUM_BP   = 2,
  parameter int         STEP_W   = 8,
  parameter int         NMI_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           A,
  input  logic                 write,
  input  logic [7:0]           Din,
  output logic [7:0]           Dout,
  output logic                 win_hit,
  input  logic                 sync,
  input  logic [15:0]          cpu_addr,
  input  logic                 b_runhalt,
  input  logic                 b_step,
  input  logic                 b_reset,
  input  logic [STEP_W-1:0]    step_count,
  input  logic [NUM_BP*16-1:0] bp_addr,
  input  logic [NUM_BP-1:0]    bp_en,
  output logic                 nmiN,
  output logic                 stopped,
  output logic [NUM_BP-1:0]    bp_hit
);

  localparam int CNT_W = STEP_W + 1;

  dbg_state_e state_q, state_d;

  logic [8:0]        win_diff;
  logic [3:0]        win_off;
  logic              reg_wr, resume;
  logic [6:0][7:0]   regs_q, regs_d;
  logic [7:0]        dout_q, dout_d, status, rd_data;
  logic [2:0]        sync_pipe_q, sync_pipe_d;
  logic              sync_rise;
  logic [NUM_BP-1:0] bp_match, bp_hit_q, bp_hit_d;
  logic [STEP_W-1:0] step_n_q, step_n_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic              fire, step_active;

  // 9-bit difference: bit 8 set means A is below the base, so no wrap alias.
  assign win_diff = {1'b0, A} - {1'b0, WIN_BASE};
  assign win_hit  = (win_diff[8:4] == 5'd0);
  assign win_off  = win_diff[3:0];

  assign reg_wr = write & win_hit & (win_off <= OFF_REG_LAST);
  assign resume = write & win_hit & (win_off == OFF_STATUS) & Din[0];

  assign stopped     = (state_q == ST_STOP);
  assign step_active = (state_q == ST_ARMED) || (state_q == ST_STEPPING);

  // sync_pipe_q[1:0] is the two-flop synchroniser, [2] the edge-detect history.
  assign sync_pipe_d = {sync_pipe_q[1:0], sync};
  assign sync_rise   = sync_pipe_q[1] & ~sync_pipe_q[2];

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[16*i +: 16] == cpu_addr)) begin
        bp_match[i] = 1'b1;
      end
    end
  end

  always_comb begin
    status                   = '0;
    status[STAT_STOPPED_BIT] = stopped;
    status[STAT_BP_BIT]      = |bp_hit_q;
    status[STAT_STEP_BIT]    = step_active;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    if (win_off <= OFF_REG_LAST) begin
      rd_data = regs_q[win_off[2:0]];
    end else if (win_off == OFF_STATUS) begin
      rd_data = status;
    end
    regs_d = regs_q;
    if (reg_wr) begin
      regs_d[win_off[2:0]] = Din;
    end
    dout_d = win_hit ? rd_data : dout_q;
  end

  always_comb begin
    state_d    = state_q;
    fire       = 1'b0;
    step_n_d   = step_n_q;
    step_cnt_d = step_cnt_q;
    bp_hit_d   = resume ? '0 : bp_hit_q;
    unique case (state_q)
      ST_RUN: begin
        if (b_step || b_runhalt) begin
          fire    = 1'b1;
          state_d = ST_STOP;
        end else if (sync_rise && (|bp_match)) begin
          bp_hit_d = bp_hit_d | bp_match;
          fire     = 1'b1;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (b_reset) begin
          step_cnt_d = '0;
          state_d    = ST_RESETSTEP;
        end else if (b_runhalt) begin
          state_d = ST_RUN;
        end else if (b_step) begin
          step_n_d = (step_count == '0) ? STEP_W'(1) : step_count;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (b_reset) begin
          state_d = ST_RUN;
        end else if (resume) begin
          step_cnt_d = '0;
          state_d    = ST_STEPPING;
        end
      end
      ST_STEPPING: begin
        // The first rise is the RTI fetch, so N instructions end on rise N+1.
        if (b_reset) begin
          state_d = ST_RUN;
        end else if (sync_rise) begin
          if (step_cnt_q == {1'b0, step_n_q}) begin
            fire    = 1'b1;
            state_d = ST_STOP;
          end else begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RESETSTEP: begin
        if (b_reset) begin
          state_d = ST_RUN;
        end else if (sync_rise) begin
          fire    = 1'b1;
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      // NOTE: the CPU register file is tiny and must read 0 after reset, so it is reset too.
      regs_q      <= '0;
      dout_q      <= '0;
      sync_pipe_q <= '0;
      bp_hit_q    <= '0;
      step_n_q    <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      dout_q      <= dout_d;
      sync_pipe_q <= sync_pipe_d;
      bp_hit_q    <= bp_hit_d;
      step_n_q    <= step_n_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  nmi_pulse_gen #(
    .NMI_LEN(NMI_LEN)
  ) u_nmi (
    .clk  (clk),
    .rst_n(rst_n),
    .fire (fire),
    .nmi_n(nmiN)
  );

  assign Dout   = dout_q;
  assign bp_hit = bp_hit_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Scoreboard bench for cpu_debug_ctrl: stimulus queues expected window reads
// and NMI pulse widths; independent monitors compare whenever the DUT responds.
module tb_cpu_debug_ctrl;

  localparam logic [7:0] WIN_BASE = 8'hE0;

  logic        clk, rst_n;
  logic [7:0]  A, Din, Dout;
  logic        write, win_hit, sync;
  logic [15:0] cpu_addr;
  logic        b_runhalt, b_step, b_reset;
  logic [7:0]  step_count;
  logic [31:0] bp_addr;
  logic [1:0]  bp_en, bp_hit;
  logic        nmiN, stopped;

  cpu_debug_ctrl #(
    .WIN_BASE(WIN_BASE),
    .NUM_BP  (2),
    .STEP_W  (8),
    .NMI_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .write     (write),
    .Din       (Din),
    .Dout      (Dout),
    .win_hit   (win_hit),
    .sync      (sync),
    .cpu_addr  (cpu_addr),
    .b_runhalt (b_runhalt),
    .b_step    (b_step),
    .b_reset   (b_reset),
    .step_count(step_count),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .nmiN      (nmiN),
    .stopped   (stopped),
    .bp_hit    (bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic [1:0] bp;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      nmi_q[$];
  int      n_vec  = 0;
  int      n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    n_vec++;
    n_miss++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Read monitor: a cycle with win_hit high yields Dout after the next edge.
  logic    rd_pend = 1'b0;
  rd_exp_t rd_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          flag("unexpected_read", "window access with nothing expected");
        end else begin
          rd_e = rd_q.pop_front();
          check({rd_e.name, "_dout"}, 32'(Dout), 32'(rd_e.dout));
          check({rd_e.name, "_bp_hit"}, 32'(bp_hit), 32'(rd_e.bp));
        end
      end
      rd_pend = win_hit;
    end
  end

  // NMI monitor: measures each low pulse and pairs it with the next expected width.
  int low_cnt = 0;
  always @(negedge clk) begin
    if (nmiN === 1'b0) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      if (nmi_q.size() == 0) begin
        flag("unexpected_nmi", $sformatf("pulse of %0d cycles", low_cnt));
      end else begin
        check("nmi_width", 32'(low_cnt), 32'(nmi_q.pop_front()));
      end
      low_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [3:0] off, input logic [7:0] exp, input logic [1:0] bp,
                    input string name);
    rd_q.push_back('{name: name, dout: exp, bp: bp});
    A     = WIN_BASE + {4'b0, off};
    write = 1'b0;
    tick(1);
    A = 8'h00;
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] data, input logic [7:0] exp_old,
                    input logic [1:0] bp, input string name);
    rd_q.push_back('{name: name, dout: exp_old, bp: bp});
    A     = WIN_BASE + {4'b0, off};
    Din   = data;
    write = 1'b1;
    tick(1);
    write = 1'b0;
    A     = 8'h00;
  endtask

  task automatic btn(input int which);
    case (which)
      0:       b_runhalt = 1'b1;
      1:       b_step    = 1'b1;
      default: b_reset   = 1'b1;
    endcase
    tick(1);
    b_runhalt = 1'b0;
    b_step    = 1'b0;
    b_reset   = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] addr);
    cpu_addr = addr;
    sync     = 1'b1;
    tick(4);
    sync = 1'b0;
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    A = 8'h00; write = 1'b0; Din = 8'h00; sync = 1'b0; cpu_addr = 16'h0000;
    b_runhalt = 1'b0; b_step = 1'b0; b_reset = 1'b0; step_count = 8'd0;
    bp_addr = 32'h0; bp_en = 2'b00; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(Dout), 32'h00);
    check("reset_nmin", 32'(nmiN), 32'h1);
    check("reset_stopped", 32'(stopped), 32'h0);
    check("reset_bp_hit", 32'(bp_hit), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Register window, including same-edge write returning the old value.
    wr(4'd0, 8'h5A, 8'h00, 2'b00, "wr_acc");
    rd(4'd0, 8'h5A, 2'b00, "rd_acc");
    wr(4'd0, 8'h77, 8'h5A, 2'b00, "wr_acc_old");
    rd(4'd0, 8'h77, 2'b00, "rd_acc2");
    wr(4'd3, 8'hA5, 8'h00, 2'b00, "wr_sp");
    rd(4'd3, 8'hA5, 2'b00, "rd_sp");
    tick(3);
    check("dout_hold", 32'(Dout), 32'hA5);
    wr(4'd9, 8'hFF, 8'h00, 2'b00, "wr_off9");
    rd(4'd9, 8'h00, 2'b00, "rd_off9");
    rd(4'd15, 8'h00, 2'b00, "rd_off15");
    rd(4'd6, 8'h00, 2'b00, "rd_sr");
    rd(4'd7, 8'h00, 2'b00, "status_run");
    A = 8'hDF; #1 check("win_hit_below", 32'(win_hit), 32'h0);
    A = 8'hF0; #1 check("win_hit_above", 32'(win_hit), 32'h0);
    A = 8'hEF; #1 check("win_hit_top", 32'(win_hit), 32'h1);
    A = 8'h00;
    tick(1);

    // Halt from RUN.
    nmi_q.push_back(4);
    btn(0);
    tick(6);
    rd(4'd7, 8'h80, 2'b00, "status_halt");

    // Multi-step of 3: RTI fetch plus 3 instructions, NMI on the 4th rise.
    step_count = 8'd3;
    btn(1);
    rd(4'd7, 8'h20, 2'b00, "status_armed");
    wr(4'd7, 8'h01, 8'h20, 2'b00, "resume");
    rd(4'd7, 8'h20, 2'b00, "status_stepping");
    fetch(16'h8000);
    fetch(16'h8001);
    fetch(16'h8003);
    rd(4'd7, 8'h20, 2'b00, "status_after3");
    nmi_q.push_back(4);
    fetch(16'h8005);
    tick(2);
    rd(4'd7, 8'h80, 2'b00, "status_after4");

    // Back to RUN, then breakpoints (entry 0 matches too but is disabled).
    btn(0);
    rd(4'd7, 8'h00, 2'b00, "status_run2");
    bp_en   = 2'b10;
    bp_addr = {16'hC012, 16'hC012};
    fetch(16'h1000);
    rd(4'd7, 8'h00, 2'b00, "bp_nomatch");
    nmi_q.push_back(4);
    fetch(16'hC012);
    tick(2);
    rd(4'd7, 8'hC0, 2'b10, "bp_status");
    wr(4'd7, 8'h01, 8'hC0, 2'b00, "bp_clear");
    rd(4'd7, 8'h80, 2'b00, "bp_cleared");
    bp_en = 2'b00;

    // step_count = 0 behaves as a single step.
    step_count = 8'd0;
    btn(1);
    wr(4'd7, 8'h01, 8'h20, 2'b00, "resume_n0");
    fetch(16'h2000);
    rd(4'd7, 8'h20, 2'b00, "step0_after1");
    nmi_q.push_back(4);
    fetch(16'h2002);
    tick(2);
    rd(4'd7, 8'h80, 2'b00, "step0_done");

    // b_reset mid-step aborts to RUN with no NMI.
    step_count = 8'd5;
    btn(1);
    wr(4'd7, 8'h01, 8'h20, 2'b00, "resume_abort");
    fetch(16'h3000);
    fetch(16'h3001);
    btn(2);
    rd(4'd7, 8'h00, 2'b00, "abort_run");
    tick(10);
    check("abort_nmin", 32'(nmiN), 32'h1);

    // Reset-step: halt, b_reset, NMI on the first fetch.
    nmi_q.push_back(4);
    btn(0);
    tick(6);
    btn(2);
    rd(4'd7, 8'h00, 2'b00, "status_resetstep");
    nmi_q.push_back(4);
    fetch(16'hFFFC);
    tick(2);
    rd(4'd7, 8'h80, 2'b00, "resetstep_done");

    // rst_n mid-pulse truncates the NMI to the two cycles already low.
    btn(0);
    nmi_q.push_back(2);
    btn(0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_nmin", 32'(nmiN), 32'h1);
    check("rst_mid_stopped", 32'(stopped), 32'h0);
    rst_n = 1'b1;
    tick(2);
    rd(4'd0, 8'h00, 2'b00, "acc_after_rst");
    rd(4'd7, 8'h00, 2'b00, "status_after_rst");
    tick(12);
    check("after_rst_nmin", 32'(nmiN), 32'h1);

    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("nmi_queue_drained", 32'(nmi_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
